// File: rtl/cc_fill_pkg.sv
// Shared types and derived-width helpers for the cache line-fill engine.
// Optional macro CC_FILL_CWF_FWD_EN (used by the top) enables critical-word forwarding.
package cc_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } fill_state_e;

    function automatic int calc_ofs_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_beats(input int line_bytes, input int beat_w);
        return (line_bytes * 8) / beat_w;
    endfunction

    function automatic int calc_cnt_w(input int line_bytes, input int beat_w);
        return $clog2(calc_beats(line_bytes, beat_w));
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int idx_w, input int line_bytes);
        return addr_w - idx_w - calc_ofs_w(line_bytes);
    endfunction

    // Extracts a width-bit field starting at lsb; callers cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb, input int width);
        return (addr >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/cc_line_deser.sv
// Beat-slot register: stores each incoming beat into its wrapped slot of the line buffer.
module cc_line_deser
    import cc_fill_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [$clog2(BEATS)-1:0]  slot,
    input  logic [BEAT_W-1:0]         din,
    output logic [BEATS*BEAT_W-1:0]   line
);

    logic [BEAT_W-1:0] slot_r [BEATS];

    // Slot storage; reset discards any partially assembled line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < BEATS; k++) begin
                slot_r[k] <= '0;
            end
        end else if (we) begin
            slot_r[slot] <= din;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line[g*BEAT_W +: BEAT_W] = slot_r[g];
    end

endmodule

// File: rtl/cc_line_fill_unit.sv
// Cache line-fill engine: pops a miss, gathers a critical-word-first burst, writes the line.
// Define CC_FILL_CWF_FWD_EN to add the registered critical-word forwarding outputs.
module cc_line_fill_unit
    import cc_fill_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int IDX_W      = 9
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [BEAT_W-1:0]                                 mem_rdata_i,
    input  logic                                              mem_rlast_i,
    input  logic                                              mem_rvalid_i,
    output logic                                              mem_rready_o,
    input  logic                                              miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]                                 miss_addr_fifo_rdata_i,
    output logic                                              miss_addr_fifo_rden_o,
    output logic                                              wren_o,
    output logic [IDX_W-1:0]                                  waddr_o,
    output logic [calc_tag_w(ADDR_W, IDX_W, LINE_BYTES):0]    wdata_tag_o,
    output logic [LINE_BYTES*8-1:0]                           wdata_data_o,
`ifdef CC_FILL_CWF_FWD_EN
    output logic                                              fwd_valid_o,
    output logic [BEAT_W-1:0]                                 fwd_data_o,
    output logic [IDX_W-1:0]                                  fwd_idx_o,
`endif
    output logic                                              err_o
);

    localparam int OFS_W = calc_ofs_w(LINE_BYTES);
    localparam int BEATS = calc_beats(LINE_BYTES, BEAT_W);
    localparam int CNT_W = calc_cnt_w(LINE_BYTES, BEAT_W);
    localparam int TAG_W = calc_tag_w(ADDR_W, IDX_W, LINE_BYTES);

    fill_state_e        state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   start_r;
    logic [IDX_W-1:0]   idx_r;
    logic [TAG_W-1:0]   tag_r;
    logic               err_r;
    logic               pop_s;
    logic               beat_s;
    logic               last_s;
    logic [CNT_W-1:0]   slot_s;

    // A new miss may be taken from IDLE or straight out of WRITE for back-to-back fills.
    assign pop_s  = !rst && !miss_addr_fifo_empty_i && (state_r == IDLE || state_r == WRITE);
    assign beat_s = (state_r == FILL) && mem_rvalid_i;
    assign last_s = beat_s && (cnt_r == CNT_W'(BEATS - 1));
    assign slot_s = start_r + cnt_r;

    // Next-state logic; error never alters sequencing.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (pop_s)  state_s = FILL;  else state_s = IDLE;
            FILL:    if (last_s) state_s = WRITE; else state_s = FILL;
            WRITE:   if (pop_s)  state_s = FILL;  else state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, beat counter, latched miss fields and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            start_r <= '0;
            idx_r   <= '0;
            tag_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (pop_s) begin
                cnt_r   <= '0;
                start_r <= CNT_W'(addr_field(64'(miss_addr_fifo_rdata_i), OFS_W - CNT_W, CNT_W));
                idx_r   <= IDX_W'(addr_field(64'(miss_addr_fifo_rdata_i), OFS_W, IDX_W));
                tag_r   <= TAG_W'(addr_field(64'(miss_addr_fifo_rdata_i), OFS_W + IDX_W, TAG_W));
            end else if (beat_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (beat_s && mem_rlast_i && !last_s) begin
                err_r <= 1'b1;
            end
        end
    end

    cc_line_deser #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_deser (
        .clk  (clk),
        .rst  (rst),
        .we   (beat_s),
        .slot (slot_s),
        .din  (mem_rdata_i),
        .line (wdata_data_o)
    );

`ifdef CC_FILL_CWF_FWD_EN
    logic              fwd_valid_r;
    logic [BEAT_W-1:0] fwd_data_r;
    logic [IDX_W-1:0]  fwd_idx_r;

    // Early return of the critical (first) beat of each fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_r <= 1'b0;
            fwd_data_r  <= '0;
            fwd_idx_r   <= '0;
        end else begin
            fwd_valid_r <= beat_s && (cnt_r == '0);
            if (beat_s && (cnt_r == '0)) begin
                fwd_data_r <= mem_rdata_i;
                fwd_idx_r  <= idx_r;
            end
        end
    end

    assign fwd_valid_o = fwd_valid_r;
    assign fwd_data_o  = fwd_data_r;
    assign fwd_idx_o   = fwd_idx_r;
`endif

    assign mem_rready_o          = (state_r == FILL);
    assign miss_addr_fifo_rden_o = pop_s;
    assign wren_o                = (state_r == WRITE);
    assign waddr_o               = idx_r;
    assign wdata_tag_o           = {wren_o, tag_r};
    assign err_o                 = err_r;

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Directed self-checking bench for cc_line_fill_unit (default parameters).
module tb_cc_line_fill_unit;

    localparam int BEAT_W = 64;
    localparam int BEATS  = 8;
    localparam int IDX_W  = 9;
    localparam int TAG_W  = 17;
    localparam int LINE_W = 512;

    typedef logic [BEAT_W-1:0] beats_t [BEATS];

    logic              clk = 1'b0;
    logic              rst;
    logic [BEAT_W-1:0] mem_rdata_i;
    logic              mem_rlast_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;
    logic              fifo_empty;
    logic [31:0]       fifo_rdata;
    logic              fifo_rden;
    logic              wren_o;
    logic [IDX_W-1:0]  waddr_o;
    logic [TAG_W:0]    wdata_tag_o;
    logic [LINE_W-1:0] wdata_data_o;
    logic              err_o;
`ifdef CC_FILL_CWF_FWD_EN
    logic              fwd_valid_o;
    logic [BEAT_W-1:0] fwd_data_o;
    logic [IDX_W-1:0]  fwd_idx_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cc_line_fill_unit dut (
        .clk                    (clk),
        .rst                    (rst),
        .mem_rdata_i            (mem_rdata_i),
        .mem_rlast_i            (mem_rlast_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_o           (mem_rready_o),
        .miss_addr_fifo_empty_i (fifo_empty),
        .miss_addr_fifo_rdata_i (fifo_rdata),
        .miss_addr_fifo_rden_o  (fifo_rden),
        .wren_o                 (wren_o),
        .waddr_o                (waddr_o),
        .wdata_tag_o            (wdata_tag_o),
        .wdata_data_o           (wdata_data_o),
`ifdef CC_FILL_CWF_FWD_EN
        .fwd_valid_o            (fwd_valid_o),
        .fwd_data_o             (fwd_data_o),
        .fwd_idx_o              (fwd_idx_o),
`endif
        .err_o                  (err_o)
    );

    // Miss-address FIFO model (show-ahead), popped at the edge after rden is seen.
    logic [31:0] fifo_mem [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        pop_seen = 1'b0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fifo_mem[rd_ptr % 16];

    always @(posedge clk) if (pop_seen) rd_ptr <= rd_ptr + 1;

    // Monitor: cycle counter, write captures, pop and error-rise timing.
    int                cyc = 0;
    int                wr_cnt = 0;
    int                err_rise = -1;
    int                wr_cycs [$];
    int                rd_cycs [$];
    logic [IDX_W-1:0]  wr_addr_q [$];
    logic [TAG_W:0]    wr_tag_q [$];
    logic [LINE_W-1:0] wr_data_q [$];
    int                acc_cyc [BEATS];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pop_seen = fifo_rden;
        if (fifo_rden) rd_cycs.push_back(cyc);
        if (wren_o) begin
            wr_cnt++;
            wr_cycs.push_back(cyc);
            wr_addr_q.push_back(waddr_o);
            wr_tag_q.push_back(wdata_tag_o);
            wr_data_q.push_back(wdata_data_o);
        end
        if (err_o === 1'b1 && err_rise < 0) err_rise = cyc;
    end

    function automatic beats_t make_beats(input int t);
        beats_t d;
        for (int k = 0; k < BEATS; k++) d[k] = 64'hD00D_0000_0000_0000 + 64'(t << 16) + 64'(k);
        return d;
    endfunction

    function automatic logic [LINE_W-1:0] build_line(input beats_t d, input int start);
        logic [LINE_W-1:0] l = '0;
        for (int k = 0; k < BEATS; k++) l[((start + k) % BEATS)*BEAT_W +: BEAT_W] = d[k];
        return l;
    endfunction

    task automatic push_miss(input logic [31:0] a);
        fifo_mem[wr_ptr % 16] = a;
        wr_ptr++;
    endtask

    task automatic send_beats(input beats_t d, input int nbeats, input int rlast_pos, input bit toggle);
        int i = 0;
        int budget = 0;
        bit phase = 1'b1;
        bit acc;
        while (i < nbeats && budget < 200) begin
            mem_rdata_i  = d[i];
            mem_rlast_i  = (i == rlast_pos);
            mem_rvalid_i = toggle ? phase : 1'b1;
            @(negedge clk);
            acc = mem_rvalid_i && mem_rready_o;
            if (acc) acc_cyc[i] = cyc;
            @(posedge clk); #1;
            if (acc) i++;
            phase = ~phase;
            budget++;
        end
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        n_checks++;
        if (i !== nbeats) begin
            n_fail++;
            $display("FAIL beat_accept: got %0d beats, expected %0d", i, nbeats);
        end
    endtask

    task automatic wait_wren(input int n);
        int b = 0;
        while (wr_cnt < n && b < 50) begin
            @(negedge clk);
            b++;
        end
        n_checks++;
        if (wr_cnt < n) begin
            n_fail++;
            $display("FAIL wren_timeout: got %0d writes, expected %0d", wr_cnt, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({wren_o, mem_rready_o, fifo_rden, err_o} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {wren_o, mem_rready_o, fifo_rden, err_o}); end
        n_checks++; if (waddr_o !== '0 || wdata_tag_o !== '0) begin n_fail++;
            $display("FAIL reset_addr: got %h/%h expected 0/0", waddr_o, wdata_tag_o); end
        n_checks++; if (wdata_data_o !== '0) begin n_fail++;
            $display("FAIL reset_data: got %h expected 0", wdata_data_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_fill(input string nm, input logic [31:0] a, input logic [IDX_W-1:0] eidx,
                             input logic [TAG_W-1:0] etag, input int start, input bit toggle, input int t);
        beats_t d = make_beats(t);
        int n0 = wr_cnt;
        push_miss(a);
        send_beats(d, BEATS, BEATS - 1, toggle);
        wait_wren(n0 + 1);
        repeat (3) @(negedge clk);
        n_checks++; if (wr_cnt !== n0 + 1) begin n_fail++;
            $display("FAIL %s_count: got %0d expected %0d", nm, wr_cnt, n0 + 1); end
        n_checks++; if (wr_cycs[n0] !== acc_cyc[BEATS-1] + 1) begin n_fail++;
            $display("FAIL %s_latency: got cyc %0d expected %0d", nm, wr_cycs[n0], acc_cyc[BEATS-1] + 1); end
        n_checks++; if (wr_addr_q[n0] !== eidx || wr_tag_q[n0] !== {1'b1, etag}) begin n_fail++;
            $display("FAIL %s_addr: got %h/%h expected %h/%h", nm, wr_addr_q[n0], wr_tag_q[n0], eidx, {1'b1, etag}); end
        n_checks++; if (wr_data_q[n0] !== build_line(d, start)) begin n_fail++;
            $display("FAIL %s_data: got %h expected %h", nm, wr_data_q[n0], build_line(d, start)); end
    endtask

    task automatic test_back_to_back();
        beats_t d0 = make_beats(30);
        beats_t d1 = make_beats(31);
        int n0 = wr_cnt;
        rd_cycs.delete();
        push_miss(32'h0000_2080);
        push_miss(32'h0004_80F8);
        send_beats(d0, BEATS, BEATS - 1, 1'b0);
        send_beats(d1, BEATS, BEATS - 1, 1'b0);
        wait_wren(n0 + 2);
        n_checks++; if (rd_cycs.size() !== 2 || rd_cycs[1] !== wr_cycs[n0]) begin n_fail++;
            $display("FAIL b2b_pop: got %0d pops, 2nd at %0d, expected 2 at %0d", rd_cycs.size(), rd_cycs[1], wr_cycs[n0]); end
        n_checks++; if (wr_cycs[n0+1] - wr_cycs[n0] !== 9) begin n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 9", wr_cycs[n0+1] - wr_cycs[n0]); end
        n_checks++; if (wr_data_q[n0] !== build_line(d0, 0) || wr_addr_q[n0] !== 9'h082) begin n_fail++;
            $display("FAIL b2b_first: got %h idx %h expected idx 082", wr_data_q[n0], wr_addr_q[n0]); end
        n_checks++; if (wr_data_q[n0+1] !== build_line(d1, 7) || wr_tag_q[n0+1] !== {1'b1, 17'd9} || wr_addr_q[n0+1] !== 9'h003) begin n_fail++;
            $display("FAIL b2b_second: got %h tag %h idx %h expected tag %h idx 003", wr_data_q[n0+1], wr_tag_q[n0+1], wr_addr_q[n0+1], {1'b1, 17'd9}); end
    endtask

    task automatic test_early_rlast();
        beats_t d = make_beats(50);
        int n0 = wr_cnt;
        n_checks++; if (err_o !== 1'b0) begin n_fail++;
            $display("FAIL err_before: got %b expected 0", err_o); end
        push_miss(32'h0000_7FC0);
        send_beats(d, BEATS, 3, 1'b0);
        wait_wren(n0 + 1);
        n_checks++; if (err_rise !== acc_cyc[3] + 1) begin n_fail++;
            $display("FAIL err_rise: got cyc %0d expected %0d", err_rise, acc_cyc[3] + 1); end
        n_checks++; if (wr_cycs[n0] !== acc_cyc[BEATS-1] + 1 || wr_data_q[n0] !== build_line(d, 0) || wr_addr_q[n0] !== 9'h1FF) begin n_fail++;
            $display("FAIL err_fill: got cyc %0d idx %h expected cyc %0d idx 1ff", wr_cycs[n0], wr_addr_q[n0], acc_cyc[BEATS-1] + 1); end
        repeat (4) @(negedge clk);
        n_checks++; if (err_o !== 1'b1) begin n_fail++;
            $display("FAIL err_sticky: got %b expected 1", err_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill();
        beats_t d = make_beats(60);
        int n0 = wr_cnt;
        push_miss(32'h0000_1000);
        send_beats(d, 3, 99, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (err_o !== 1'b0 || mem_rready_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_state: got err %b rready %b expected 0 0", err_o, mem_rready_o); end
        repeat (12) @(negedge clk);
        n_checks++; if (wr_cnt !== n0) begin n_fail++;
            $display("FAIL rst_mid_nowrite: got %0d writes expected %0d", wr_cnt, n0); end
        @(posedge clk); #1;
        test_fill("after_rst", 32'hFFFF_FFF8, 9'h1FF, 17'h1FFFF, 7, 1'b0, 61);
        n_checks++; if (err_o !== 1'b0) begin n_fail++;
            $display("FAIL after_rst_err: got %b expected 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_fill("basic", 32'h0000_1040, 9'h041, 17'h0, 0, 1'b0, 1);
        test_fill("wrap", 32'h0000_1068, 9'h041, 17'h0, 5, 1'b0, 2);
        test_back_to_back();
        test_fill("stall", 32'h0001_4010, 9'h100, 17'd2, 2, 1'b1, 4);
        test_early_rlast();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
